// File: rtl/mult3_rr_sched_pkg.sv
// Shared types and helpers for the mult3_rr_sched block: operand/product
// widths, the scheduler state encoding, and the rotating-priority search.
package mult3_sched_pkg;

  localparam int OP_W    = 3;
  localparam int PROD_W  = 6;
  localparam int MAX_REQ = 8;
  localparam int GIDX_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic              found;
    logic [GIDX_W-1:0] idx;
  } grant_t;

  // Rotating-priority search: start one past the last winner, wrap at n,
  // first set bit wins. Bits of valid at or above n are ignored.
  function automatic grant_t next_rr_grant(input logic [MAX_REQ-1:0] valid,
                                           input logic [GIDX_W-1:0]  last,
                                           input int                 n);
    grant_t r;
    int     j;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !r.found) begin
        j = (int'(last) + k) % n;
        if (valid[GIDX_W'(j)]) begin
          r.found = 1'b1;
          r.idx   = GIDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mult3_rr_sched_arb.sv
// Round-robin arbiter: one-hot grant from the request vector, starting the
// search just past the last winner. The pointer only moves when the grant
// is actually taken (en_i high and a winner exists).
module rr_arbiter
  import mult3_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] last_q, last_d;
  grant_t           pick;

  // Winner search and one-hot decode; pointer advances only on a taken grant
  always_comb begin
    pick      = next_rr_grant(MAX_REQ'(req_i), GIDX_W'(last_q), N);
    gnt_o     = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = en_i & pick.found & (pick.idx == GIDX_W'(i));
    end
    gnt_idx_o = pick.idx[IDX_W-1:0];
    found_o   = pick.found;
    last_d    = (en_i & pick.found) ? pick.idx[IDX_W-1:0] : last_q;
  end

  // Last-grant pointer; reset to N-1 so requester 0 is searched first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= IDX_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/multiplier_3bit.sv
// Unsigned 3x3 array multiplier: partial-product rows accumulated by two
// ripple adder rows, one product bit retired per row.
module multiplier_3bit (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic [5:0] p_o
);

  logic [2:0] pp0, pp1, pp2;
  logic [3:0] row1, row2;

  // Partial products and the two accumulation rows
  always_comb begin
    pp0  = a_i & {3{b_i[0]}};
    pp1  = a_i & {3{b_i[1]}};
    pp2  = a_i & {3{b_i[2]}};
    row1 = 4'({1'b0, pp0[2:1]}) + 4'(pp1);
    row2 = 4'(row1[3:1]) + 4'(pp2);
    p_o  = {row2, row1[0], pp0[0]};
  end

endmodule

// File: rtl/mult3_rr_sched.sv
// Round-robin scheduler sharing one 3x3 unsigned multiplier among NUM_REQ
// requesters. One accept per cycle, product registered with requester id,
// back-to-back issue while the downstream keeps rsp_ready high.
// Optional build macro MULT3_RR_SCHED_STATS_EN adds a saturating 16-bit
// accepted-transfer counter on output op_count.
module mult3_rr_sched
  import mult3_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [3*NUM_REQ-1:0]    req_a,
  input  logic [3*NUM_REQ-1:0]    req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PROD_W-1:0]       rsp_p,
  output logic [ID_W-1:0]         rsp_id
`ifdef MULT3_RR_SCHED_STATS_EN
  ,
  output logic [15:0]             op_count
`endif
);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic                slot_free;
  logic                arb_en;
  logic                found;
  logic                xfer;
  logic [ID_W-1:0]     gnt_idx;
  logic [OP_W-1:0]     a_sel, b_sel;
  logic [PROD_W-1:0]   prod;

  // The slot is free when nothing is held or the held result leaves this
  // cycle; grants are suppressed while reset is asserted.
  always_comb begin
    slot_free = (state_q == IDLE) | ((state_q == HOLD) & rsp_ready);
    arb_en    = slot_free & rst_n;
    xfer      = arb_en & found;
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .en_i      (arb_en),
    .gnt_o     (req_ready),
    .gnt_idx_o (gnt_idx),
    .found_o   (found)
  );

  // Steer the granted requester's operands into the shared multiplier
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        a_sel = req_a[3*i +: 3];
        b_sel = req_b[3*i +: 3];
      end
    end
  end

  multiplier_3bit u_mul (
    .a_i (a_sel),
    .b_i (b_sel),
    .p_o (prod)
  );

  // Next state and product/id load: load on every transfer, otherwise
  // release the held result when the downstream takes it
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    id_d    = id_q;
    if (xfer) begin
      state_d = HOLD;
      p_d     = prod;
      id_d    = gnt_idx;
    end else if (state_q == HOLD && rsp_ready) begin
      state_d = IDLE;
    end
  end

  // State, product and id registers; reset discards any held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign rsp_p     = p_q;
  assign rsp_id    = id_q;

`ifdef MULT3_RR_SCHED_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Accepted-transfer count, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_mult3_rr_sched.sv
// Self-checking bench for mult3_rr_sched: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_mult3_rr_sched;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [3*N-1:0]  req_a;
  logic [3*N-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [5:0]      rsp_p;
  logic [1:0]      rsp_id;
`ifdef MULT3_RR_SCHED_STATS_EN
  logic [15:0]     op_count;
`endif

  logic [2:0] opa [N];
  logic [2:0] opb [N];

  int checks   = 0;
  int failures = 0;

  // Model: a held result (or none), who won last, and how many accepts
  bit m_held;
  int m_p, m_id, m_last, m_cnt, m_acc;

  mult3_rr_sched #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id)
`ifdef MULT3_RR_SCHED_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[3*i +: 3] = opa[i];
      req_b[3*i +: 3] = opb[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Requester that should win right now, -1 if none is asking
  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_ready();
    int w;
    w = winner();
    if (!rst_n) return 0;
    if ((!m_held || rsp_ready) && w >= 0) return 32'(1) << w;
    return 0;
  endfunction

  task automatic model_reset();
    m_held = 0; m_p = 0; m_id = 0; m_last = N - 1; m_cnt = 0;
  endtask

  // One cycle: compare all outputs mid-cycle, then advance the model at the edge
  task automatic tick();
    int w;
    bit sf;
    #2;
    chk("req_ready", req_ready, exp_ready());
    chk("rsp_valid", rsp_valid, m_held);
    chk("rsp_p", rsp_p, m_p);
    chk("rsp_id", rsp_id, m_id);
`ifdef MULT3_RR_SCHED_STATS_EN
    chk("op_count", op_count, m_cnt);
`endif
    w  = winner();
    sf = !m_held || rsp_ready;
    @(posedge clk);
    m_acc = -1;
    if (!rst_n) begin
      model_reset();
    end else if (sf && w >= 0) begin
      m_held = 1;
      m_p    = opa[w] * opb[w];
      m_id   = w;
      m_last = w;
      m_acc  = w;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_held && rsp_ready) begin
      m_held = 0;
    end
    #1;
    if (m_acc >= 0) req_valid[m_acc] = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset: outputs cleared and nothing granted even with requests pending
    req_valid = 4'b1111;
    #1 chk("rst_ready", req_ready, 0);
    tick();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_p", rsp_p, 0);
    chk("rst_id", rsp_id, 0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single request 5*7 on requester 0
    opa[0] = 3'd5; opb[0] = 3'd7; req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_p", rsp_p, 35);
    chk("t1_id", rsp_id, 0);
    tick();
    chk("t1_idle", rsp_valid, 0);

    // Fresh reset, then all four valid: grants 0..3 back to back
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin opa[i] = 3'(i + 1); opb[i] = 3'd7; end
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      #1 chk("t2_ready", req_ready, 32'(1) << k);
      tick();
      chk("t2_p", rsp_p, 7 * (k + 1));
      chk("t2_id", rsp_id, k);
    end
    tick();

    // Backpressure: 6*6 held for three cycles while requester 2 waits
    opa[0] = 3'd6; opb[0] = 3'd6; req_valid = 4'b0001;
    tick();
    rsp_ready = 1'b0;
    opa[2] = 3'd3; opb[2] = 3'd5; req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_p", rsp_p, 36);
      chk("t3_hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t3_release_ready", req_ready, 4'b0100);
    tick();
    chk("t3_p", rsp_p, 15);
    chk("t3_id", rsp_id, 2);
    tick();

    // Operand extremes
    opa[0] = 3'd0; opb[0] = 3'd6; req_valid = 4'b0001;
    tick();
    chk("t4_zero", rsp_p, 0);
    opa[1] = 3'd7; opb[1] = 3'd7; req_valid = 4'b0010;
    tick();
    chk("t4_max", rsp_p, 49);
    tick();

    // Reset in the middle of a held result; requester 0 wins afterwards
    opa[0] = 3'd2; opb[0] = 3'd3; req_valid = 4'b0001;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("t5_held", rsp_valid, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_valid", rsp_valid, 0);
    chk("t5_p", rsp_p, 0);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1 chk("t5_first", req_ready, 4'b0001);
    tick();

    // Random traffic with stable operands while waiting and occasional withdrawal
    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          opa[i] = 3'($urandom);
          opb[i] = 3'($urandom);
        end
      end
      tick();
    end

`ifdef MULT3_RR_SCHED_STATS_EN
    // Saturation of the accept counter
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (70000) @(posedge clk);
    #1 chk("stats_sat", op_count, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
